memory_mod: RTL and testbench



---
 rtl/memory_mod.sv | 55 +++++
 tb/tb_memory_mod.sv | 137 +++++++++++++
 2 files changed

// File: rtl/memory_mod.sv
// Delay-line sample memory: synchronous write, combinational write-first read, zero latency.
// Define MEMORY_MOD_REG_OUT_EN to register d_out (1-cycle latency, cleared by rst).
module memory_mod #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 15,
  parameter int DEPTH  = 29280
) (
  input  logic              w_en,
  input  logic [DATA_W-1:0] d_in,
  output logic [DATA_W-1:0] d_out,
  input  logic [ADDR_W-1:0] r_addr,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic              clk,
  input  logic              rst
);

  // One extra bit so DEPTH == 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic              w_ok;
  logic              r_ok;
  logic [DATA_W-1:0] rd_val;

  assign w_ok = w_en && !rst && ({1'b0, w_addr} < DEPTH_L);
  assign r_ok = {1'b0, r_addr} < DEPTH_L;

  always_ff @(posedge clk) begin
    if (w_ok) begin
      mem[w_addr] <= d_in;
    end
  end

  always_comb begin
    rd_val = '0;
    if (w_ok && (r_addr == w_addr)) begin
      rd_val = d_in;
    end else if (r_ok) begin
      rd_val = mem[r_addr];
    end
  end

`ifdef MEMORY_MOD_REG_OUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      d_out <= '0;
    end else begin
      d_out <= rd_val;
    end
  end
`else
  assign d_out = rd_val;
`endif

endmodule

// File: tb/tb_memory_mod.sv
// Directed self-checking bench for memory_mod; inputs change on negedge, outputs sampled off the rising edge.
module tb_memory_mod;

  localparam int DEPTH = 29280;

  logic        clk = 1'b0;
  logic        rst;
  logic        w_en;
  logic [15:0] d_in;
  logic [15:0] d_out;
  logic [14:0] r_addr;
  logic [14:0] w_addr;

  int checks = 0;
  int errors = 0;

  memory_mod dut (
    .w_en   (w_en),
    .d_in   (d_in),
    .d_out  (d_out),
    .r_addr (r_addr),
    .w_addr (w_addr),
    .clk    (clk),
    .rst    (rst)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  initial begin
    rst    = 1'b1;
    w_en   = 1'b0;
    d_in   = '0;
    r_addr = '0;
    w_addr = '0;

`ifdef MEMORY_MOD_REG_OUT_EN
    repeat (2) @(posedge clk);
    #1 check("reg_reset", d_out, 16'h0000);
    @(negedge clk);
    rst = 1'b0; w_en = 1'b1; w_addr = 15'd3; d_in = 16'h5A5A; r_addr = 15'd3;
    @(posedge clk);
    #1 check("reg_bypass", d_out, 16'h5A5A);
    @(negedge clk);
    w_en = 1'b0;
    @(posedge clk);
    #1 check("reg_read", d_out, 16'h5A5A);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 check("reg_rst_clear", d_out, 16'h0000);
`else
    // Out-of-range read is zero even while in reset with undefined contents.
    repeat (2) @(negedge clk);
    r_addr = 15'(DEPTH);
    #1 check("reset_oob_read", d_out, 16'h0000);
    rst = 1'b0;

    // Fill: sampled before the writing edge, so only the bypass can supply the data.
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      w_en = 1'b1; d_in = 16'(i); w_addr = 15'(i); r_addr = 15'(i);
      #1 check("fill_bypass", d_out, 16'(i));
    end

    @(negedge clk);
    w_en = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      r_addr = 15'(i);
      #1 check("readback", d_out, 16'(i));
    end
    r_addr = 15'd0;
    #1 check("spot_addr0", d_out, 16'h0000);
    r_addr = 15'd29279;
    #1 check("spot_last", d_out, 16'h725F);

    // Out-of-range write must neither bypass nor alias onto a valid word.
    @(negedge clk);
    w_en = 1'b1; w_addr = 15'(DEPTH); d_in = 16'hBEEF; r_addr = 15'(DEPTH);
    #1 check("oob_no_bypass", d_out, 16'h0000);
    @(negedge clk);
    w_en = 1'b0; r_addr = 15'h7FFF;
    #1 check("oob_read_max", d_out, 16'h0000);
    r_addr = 15'(DEPTH);
    #1 check("oob_read_depth", d_out, 16'h0000);
    r_addr = 15'(DEPTH - 32768 + 32767 - 32767);
    r_addr = 15'd0;
    #1 check("oob_no_alias0", d_out, 16'h0000);
    r_addr = 15'd29279;
    #1 check("oob_no_alias_last", d_out, 16'h725F);

    @(negedge clk);
    w_en = 1'b1; w_addr = 15'd5; d_in = 16'h1234; r_addr = 15'd6;
    #1 check("indep_other_addr", d_out, 16'h0006);
    @(negedge clk);
    w_en = 1'b0; r_addr = 15'd5;
    #1 check("indep_written", d_out, 16'h1234);

    // Reset cycle: write suppressed and bypass disabled.
    @(negedge clk);
    rst = 1'b1; w_en = 1'b1; w_addr = 15'd10; d_in = 16'hAAAA; r_addr = 15'd10;
    #1 check("rst_no_bypass", d_out, 16'h000A);
    @(negedge clk);
    rst = 1'b0; w_en = 1'b0;
    #1 check("rst_write_lost", d_out, 16'h000A);
    r_addr = 15'd5;
    #1 check("rst_keeps_data", d_out, 16'h1234);

    @(negedge clk);
    w_en = 1'b1; w_addr = 15'd7; d_in = 16'h1111; r_addr = 15'd8;
    @(negedge clk);
    d_in = 16'h2222;
    #1 check("wr2_other_read", d_out, 16'h0008);
    @(negedge clk);
    w_en = 1'b0; r_addr = 15'd7;
    #1 check("last_write_wins", d_out, 16'h2222);

    @(negedge clk);
    w_en = 1'b1; w_addr = 15'd29279; d_in = 16'hC0DE; r_addr = 15'd29279;
    #1 check("bypass_last_addr", d_out, 16'hC0DE);
    @(negedge clk);
    w_en = 1'b0;
    #1 check("stored_last_addr", d_out, 16'hC0DE);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
